sha512_axi_slave: RTL and testbench
===================================

Name: sha512_axi_slave

Overview:
AXI4-Lite responder (slave) fronting the SHA-512 core. It accepts single-beat register writes and reads from the PS/BFM master and holds the 1024-bit message block and control/mode bits. It issues init/next pulses to the core and exposes the 512-bit digest and status for readback. Sits between the AXI interconnect and the hash core inside the sha512 IP.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 8, byte-address width; 64 word slots.

Ports:
S_AXI_ACLK  in  1  sole clock
S_AXI_ARESET  in  1  synchronous reset, active-high
S_AXI_AWADDR  in  8  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write-address valid
S_AXI_AWREADY  out  1  write-address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write-data valid
S_AXI_WREADY  out  1  write-data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  8  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read-address valid
S_AXI_ARREADY  out  1  read-address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read valid
S_AXI_RREADY  in  1  read ready
core_init  out  1  one-cycle pulse: start new hash
core_next  out  1  one-cycle pulse: process next block
core_mode  out  2  00=512, 01=384, 10=512/256, 11=512/224
core_block  out  1024  message block; word 0 maps to [1023:992]
core_ready  in  1  core idle and able to accept a command
core_digest  in  512  digest; word 0 maps to [511:480]
core_digest_valid  in  1  digest valid

Behaviour:
- Reset values: all READY/VALID outputs 0, BRESP/RRESP 00, RDATA 0, core_init/core_next 0, core_mode 00, block and scratch registers 0.
- Register map (word-aligned; ADDR[1:0] ignored):
  - 0x00 CTRL: write bit0=INIT, bit1=NEXT (self-clearing), bits3:2=MODE. Reads return {28'b0, MODE, 2'b00}.
  - 0x04 STATUS (RO): {30'b0, digest_valid, ready}.
  - 0x08 SCRATCH (RW).
  - 0x40–0x7C DIGEST0..15 (RO).
  - 0x80–0xFC BLOCK0..31 (RW).
  - Other addresses read 0 with OKAY; writes to them are ignored with OKAY.
- Write channel:
  - AWREADY and WREADY rise together for exactly one cycle when AWVALID & WVALID & !BVALID & !aw_accepted. Address and data commit on that cycle.
  - BVALID asserts the next cycle and holds, with BRESP stable, until BREADY is sampled high.
  - Only one write is outstanding. AW without W, or W without AW, stalls with no partial acceptance.
- WSTRB: byte lane n updates bits [8n+7:8n]. Applies to SCRATCH, BLOCK and CTRL MODE; the pulse bits require strobe lane 0.
- SLVERR (2'b10), register unchanged:
  - writes to STATUS or DIGEST;
  - writes to BLOCK while core_ready=0;
  - CTRL writes with INIT or NEXT set while core_ready=0. No pulse is issued, and MODE is also left unchanged.
- Pulse timing: an accepted INIT/NEXT drives core_init/core_next high the cycle after the write commits, for exactly one cycle. If both bits are set, INIT wins and NEXT is dropped.
- Read channel:
  - ARREADY is high for one cycle when ARVALID & !RVALID.
  - RDATA is registered on that cycle. RVALID asserts the next cycle and holds, with RDATA stable, until RREADY.
  - Read latency is 1 cycle from the handshake.
- Same-cycle read and write: both are accepted independently. A read of the address being written returns the pre-write value.
- Reset mid-transaction: all handshakes are abandoned, outputs return to reset values, and any pending pulse is cancelled.

Decomposition:
- Package sha512_axi_pkg: register offsets, RESP_OKAY/RESP_SLVERR, MODE encodings, block/digest word counts.
- One natural sub-module: sha512_axi_lite_if, holding the AW/W/B and AR/R handshake FSMs. It outputs wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr, and takes wr_err and rd_data back.
- The register file and core mapping stay in the top module.

Test Plan:
- Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to SCRATCH and BLOCK0..2 (0x80, 0x84, 0x88), reading back after each -> exact data, RESP 00 throughout.
- Write CTRL=0x0000000D with core_ready=1 -> core_init high for exactly 1 cycle, core_mode=11, CTRL reads 0x0000000C.
- Hold core_ready=0, write BLOCK5=0x12345678 and CTRL=0x2 -> BRESP=10 both times, BLOCK5 unchanged, no core_next pulse.
- Drive core_digest word0=0xDEADBEEF, core_digest_valid=1, core_ready=1 -> read 0x40 returns 0xDEADBEEF, STATUS returns 0x3; write 0x40 -> BRESP=10.
- Partial strobe: write 0xFFFFFFFF with WSTRB=0101 onto SCRATCH=0 -> reads 0x00FF00FF; assert AWVALID 3 cycles before WVALID -> no AWREADY until WVALID; hold BREADY low 5 cycles -> BVALID stays high.
- Assert reset while BVALID=1 and RVALID=1 -> both deassert the next cycle and SCRATCH/BLOCK read back 0.

Source files
------------

// File: rtl/sha512_axi_slave_pkg.sv
// Package for the SHA-512 AXI4-Lite responder.
// Holds the register word indices, AXI response codes, hash mode
// encodings, the block/digest word counts, the handshake FSM state
// types and a byte-strobe merge helper.
package sha512_axi_pkg;

  // Register map as word indices (byte address >> 2).
  localparam logic [5:0] IDX_CTRL        = 6'd0;   // 0x00
  localparam logic [5:0] IDX_STATUS      = 6'd1;   // 0x04
  localparam logic [5:0] IDX_SCRATCH     = 6'd2;   // 0x08
  localparam logic [5:0] IDX_DIGEST_BASE = 6'd16;  // 0x40..0x7C
  localparam logic [5:0] IDX_BLOCK_BASE  = 6'd32;  // 0x80..0xFC

  localparam int BLOCK_WORDS  = 32;
  localparam int DIGEST_WORDS = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    MODE_512     = 2'b00,
    MODE_384     = 2'b01,
    MODE_512_256 = 2'b10,
    MODE_512_224 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ACK  = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ACK  = 2'd1,
    RD_RESP = 2'd2
  } rd_state_e;

  // Merge new_val into old_val on the byte lanes enabled by strb.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sha512_axi_slave_lite_if.sv
// AXI4-Lite handshake engine for the SHA-512 register block.
// Write side: AW and W are accepted together (one-cycle AWREADY/WREADY),
// the register file sees a single-cycle wr_en and returns wr_err, which
// is latched into BRESP; BVALID holds until BREADY.
// Read side: one-cycle ARREADY, rd_en strobes the register mux whose
// rd_data is registered into RDATA; RVALID holds until RREADY.
// Ports: clk/srst, AXI AW/W/B and AR/R channel signals, and the
// register-file side wr_en/wr_addr/wr_data/wr_strb/wr_err and
// rd_en/rd_addr/rd_data (addresses are word indices).
module sha512_axi_lite_if
  import sha512_axi_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic [7:0]  aw_addr,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_valid,
  output logic        w_ready,
  output logic [1:0]  b_resp,
  output logic        b_valid,
  input  logic        b_ready,
  input  logic [7:0]  ar_addr,
  input  logic        ar_valid,
  output logic        ar_ready,
  output logic [31:0] r_data,
  output logic [1:0]  r_resp,
  output logic        r_valid,
  input  logic        r_ready,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  input  logic        wr_err,
  output logic        rd_en,
  output logic [5:0]  rd_addr,
  input  logic [31:0] rd_data
);

  wr_state_e   wr_state_reg, wr_state_next;
  rd_state_e   rd_state_reg, rd_state_next;
  logic [1:0]  b_resp_reg;
  logic [31:0] r_data_reg;

  // Byte offset within a word is ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{aw_addr[1:0], ar_addr[1:0]};

  assign wr_addr = aw_addr[7:2];
  assign wr_data = w_data;
  assign wr_strb = w_strb;
  assign rd_addr = ar_addr[7:2];

  assign b_resp = b_resp_reg;
  assign r_data = r_data_reg;
  assign r_resp = RESP_OKAY;

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_state_reg <= WR_IDLE;
      rd_state_reg <= RD_IDLE;
      b_resp_reg   <= RESP_OKAY;
      r_data_reg   <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
      if (wr_en) b_resp_reg <= wr_err ? RESP_SLVERR : RESP_OKAY;
      // Captured on the same edge a concurrent write commits, so a read
      // of the register being written returns the old value.
      if (rd_en) r_data_reg <= rd_data;
    end
  end

  // Write FSM: address and data are only taken as a pair, so a lone AW
  // or lone W never leaves IDLE.
  always_comb begin
    wr_state_next = wr_state_reg;
    aw_ready      = 1'b0;
    w_ready       = 1'b0;
    b_valid       = 1'b0;
    wr_en         = 1'b0;
    case (wr_state_reg)
      WR_IDLE: begin
        if (aw_valid && w_valid) wr_state_next = WR_ACK;
      end
      WR_ACK: begin
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        if (aw_valid && w_valid) begin
          wr_en         = 1'b1;
          wr_state_next = WR_RESP;
        end else begin
          wr_state_next = WR_IDLE;
        end
      end
      WR_RESP: begin
        b_valid = 1'b1;
        if (b_ready) wr_state_next = WR_IDLE;
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  // Read FSM.
  always_comb begin
    rd_state_next = rd_state_reg;
    ar_ready      = 1'b0;
    r_valid       = 1'b0;
    rd_en         = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        if (ar_valid) rd_state_next = RD_ACK;
      end
      RD_ACK: begin
        ar_ready = 1'b1;
        if (ar_valid) begin
          rd_en         = 1'b1;
          rd_state_next = RD_RESP;
        end else begin
          rd_state_next = RD_IDLE;
        end
      end
      RD_RESP: begin
        r_valid = 1'b1;
        if (r_ready) rd_state_next = RD_IDLE;
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

endmodule

// File: rtl/sha512_axi_slave.sv
// AXI4-Lite register front end for the SHA-512 core.
// Holds CTRL mode, SCRATCH and the 32-word message block, issues
// one-cycle core_init/core_next pulses and exposes STATUS and the
// 16-word digest for readback.
// Ports: S_AXI_* AXI4-Lite responder (clock S_AXI_ACLK, synchronous
// active-high reset S_AXI_ARESET); core_init/core_next/core_mode/
// core_block to the hash core; core_ready/core_digest/
// core_digest_valid from it.
module sha512_axi_slave
  import sha512_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_init,
  output logic                            core_next,
  output logic [1:0]                      core_mode,
  output logic [1023:0]                   core_block,
  input  logic                            core_ready,
  input  logic [511:0]                    core_digest,
  input  logic                            core_digest_valid
);

  logic        wr_en, wr_err, rd_en;
  logic [5:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wr_strb;

  mode_e       mode_reg;
  logic [31:0] scratch_reg;
  logic        init_pulse_reg, next_pulse_reg;

  logic [31:0] block_word  [BLOCK_WORDS];
  logic [31:0] digest_word [DIGEST_WORDS];

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  sha512_axi_lite_if u_if (
    .clk      (S_AXI_ACLK),
    .srst     (S_AXI_ARESET),
    .aw_addr  (S_AXI_AWADDR),
    .aw_valid (S_AXI_AWVALID),
    .aw_ready (S_AXI_AWREADY),
    .w_data   (S_AXI_WDATA),
    .w_strb   (S_AXI_WSTRB),
    .w_valid  (S_AXI_WVALID),
    .w_ready  (S_AXI_WREADY),
    .b_resp   (S_AXI_BRESP),
    .b_valid  (S_AXI_BVALID),
    .b_ready  (S_AXI_BREADY),
    .ar_addr  (S_AXI_ARADDR),
    .ar_valid (S_AXI_ARVALID),
    .ar_ready (S_AXI_ARREADY),
    .r_data   (S_AXI_RDATA),
    .r_resp   (S_AXI_RRESP),
    .r_valid  (S_AXI_RVALID),
    .r_ready  (S_AXI_RREADY),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .wr_err   (wr_err),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  // Address class decode.
  logic wr_is_digest, wr_is_block, rd_is_digest, rd_is_block;
  logic ctrl_pulse_req;
  assign wr_is_digest = (wr_addr[5:4] == IDX_DIGEST_BASE[5:4]);
  assign wr_is_block  = (wr_addr[5]   == IDX_BLOCK_BASE[5]);
  assign rd_is_digest = (rd_addr[5:4] == IDX_DIGEST_BASE[5:4]);
  assign rd_is_block  = (rd_addr[5]   == IDX_BLOCK_BASE[5]);
  // Pulse bits only count when byte lane 0 is written.
  assign ctrl_pulse_req = wr_strb[0] && (wr_data[0] || wr_data[1]);

  // Rejected writes leave every register (including MODE) untouched.
  always_comb begin
    wr_err = 1'b0;
    if (wr_addr == IDX_STATUS || wr_is_digest) begin
      wr_err = 1'b1;
    end else if (wr_is_block && !core_ready) begin
      wr_err = 1'b1;
    end else if (wr_addr == IDX_CTRL && ctrl_pulse_req && !core_ready) begin
      wr_err = 1'b1;
    end
  end

  logic wr_ok;
  assign wr_ok = wr_en && !wr_err;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      mode_reg       <= MODE_512;
      scratch_reg    <= '0;
      init_pulse_reg <= 1'b0;
      next_pulse_reg <= 1'b0;
    end else begin
      init_pulse_reg <= 1'b0;
      next_pulse_reg <= 1'b0;
      if (wr_ok && wr_addr == IDX_CTRL && wr_strb[0]) begin
        mode_reg <= mode_e'(wr_data[3:2]);
        // INIT takes priority; a simultaneous NEXT is discarded.
        if (wr_data[0]) begin
          init_pulse_reg <= 1'b1;
        end else if (wr_data[1]) begin
          next_pulse_reg <= 1'b1;
        end
      end
      if (wr_ok && wr_addr == IDX_SCRATCH) begin
        scratch_reg <= apply_strb(scratch_reg, wr_data, wr_strb);
      end
    end
  end

  // One register per block word; word 0 lands in the top 32 bits.
  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_block
      logic [31:0] word_reg;
      always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
          word_reg <= '0;
        end else if (wr_ok && wr_is_block && wr_addr[4:0] == 5'(gi)) begin
          word_reg <= apply_strb(word_reg, wr_data, wr_strb);
        end
      end
      assign block_word[gi] = word_reg;
      assign core_block[1023-32*gi -: 32] = word_reg;
    end
    for (gi = 0; gi < DIGEST_WORDS; gi++) begin : g_digest
      assign digest_word[gi] = core_digest[511-32*gi -: 32];
    end
  endgenerate

  // Read mux; unmapped addresses return zero.
  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      if (rd_addr == IDX_CTRL) begin
        rd_data = {28'b0, mode_reg, 2'b00};
      end else if (rd_addr == IDX_STATUS) begin
        rd_data = {30'b0, core_digest_valid, core_ready};
      end else if (rd_addr == IDX_SCRATCH) begin
        rd_data = scratch_reg;
      end else if (rd_is_digest) begin
        rd_data = digest_word[rd_addr[3:0]];
      end else if (rd_is_block) begin
        rd_data = block_word[rd_addr[4:0]];
      end
    end
  end

  assign core_init = init_pulse_reg;
  assign core_next = next_pulse_reg;
  assign core_mode = mode_reg;

endmodule

// File: tb/tb_sha512_axi_slave.sv
// Directed testbench for sha512_axi_slave: register readback, byte
// strobes, INIT/NEXT pulse generation, SLVERR cases, digest/status
// readback, handshake stalls and reset in the middle of transactions.
module tb_sha512_axi_slave;

  localparam int LIMIT = 50;

  logic          clk = 1'b0;
  logic          srst;
  logic [7:0]    awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          core_init, core_next, core_ready, core_digest_valid;
  logic [1:0]    core_mode;
  logic [1023:0] core_block;
  logic [511:0]  core_digest;

  int errors = 0;
  int checks = 0;
  int init_cnt = 0;
  int next_cnt = 0;
  logic init_seen, next_seen;
  logic [1:0]  resp;
  logic [31:0] data;
  int ic, nc;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_init) init_cnt++;
    if (core_next) next_cnt++;
  end

  sha512_axi_slave dut (
    .S_AXI_ACLK        (clk),
    .S_AXI_ARESET      (srst),
    .S_AXI_AWADDR      (awaddr),
    .S_AXI_AWPROT      (awprot),
    .S_AXI_AWVALID     (awvalid),
    .S_AXI_AWREADY     (awready),
    .S_AXI_WDATA       (wdata),
    .S_AXI_WSTRB       (wstrb),
    .S_AXI_WVALID      (wvalid),
    .S_AXI_WREADY      (wready),
    .S_AXI_BRESP       (bresp),
    .S_AXI_BVALID      (bvalid),
    .S_AXI_BREADY      (bready),
    .S_AXI_ARADDR      (araddr),
    .S_AXI_ARPROT      (arprot),
    .S_AXI_ARVALID     (arvalid),
    .S_AXI_ARREADY     (arready),
    .S_AXI_RDATA       (rdata),
    .S_AXI_RRESP       (rresp),
    .S_AXI_RVALID      (rvalid),
    .S_AXI_RREADY      (rready),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_mode         (core_mode),
    .core_block        (core_block),
    .core_ready        (core_ready),
    .core_digest       (core_digest),
    .core_digest_valid (core_digest_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input int aw_lead,
                           input int b_hold, input bit finish_b,
                           output logic [1:0] r);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = wd; wstrb = strb; awvalid = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      @(negedge clk);
      chk("aw_only_awready", 32'(awready), 32'd0);
    end
    wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("wr_addr_timeout", 32'(n < LIMIT), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    init_seen = core_init; next_seen = core_next;
    n = 0;
    while (!bvalid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("wr_resp_timeout", 32'(n < LIMIT), 32'd1);
    r = bresp;
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      chk("b_hold_bvalid", 32'(bvalid), 32'd1);
      chk("b_hold_bresp", 32'(bresp), 32'(r));
    end
    if (finish_b) begin
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [7:0] addr, input bit finish_r,
                          output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!arready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("rd_addr_timeout", 32'(n < LIMIT), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("rd_data_timeout", 32'(n < LIMIT), 32'd1);
    d = rdata; r = rresp;
    if (finish_r) begin
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    core_ready = 1'b1; core_digest = '0; core_digest_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resps", 32'({bresp, rresp}), 32'd0);
    chk("rst_pulses", 32'({core_init, core_next}), 32'd0);
    chk("rst_mode", 32'(core_mode), 32'd0);
    chk("rst_block", 32'(|core_block), 32'd0);
    srst = 1'b0;

    // SCRATCH and BLOCK0..2 write/readback
    axi_write(8'h08, 32'h0101FFFF, 4'hF, 0, 0, 1, resp); chk("scratch_bresp", 32'(resp), 32'd0);
    axi_read (8'h08, 1, data, resp); chk("scratch_rd", data, 32'h0101FFFF); chk("scratch_rresp", 32'(resp), 32'd0);
    axi_write(8'h80, 32'habcd0001, 4'hF, 0, 0, 1, resp); chk("blk0_bresp", 32'(resp), 32'd0);
    axi_read (8'h80, 1, data, resp); chk("blk0_rd", data, 32'habcd0001);
    axi_write(8'h84, 32'hdead0011, 4'hF, 0, 0, 1, resp); chk("blk1_bresp", 32'(resp), 32'd0);
    axi_read (8'h84, 1, data, resp); chk("blk1_rd", data, 32'hdead0011);
    axi_write(8'h88, 32'hbeef0011, 4'hF, 0, 0, 1, resp); chk("blk2_bresp", 32'(resp), 32'd0);
    axi_read (8'h88, 1, data, resp); chk("blk2_rd", data, 32'hbeef0011); chk("blk2_rresp", 32'(resp), 32'd0);
    chk("core_block_w0", core_block[1023:992], 32'habcd0001);
    chk("core_block_w2", core_block[959:928], 32'hbeef0011);
    chk("core_block_w31", core_block[31:0], 32'd0);

    // CTRL INIT with MODE=11
    ic = init_cnt; nc = next_cnt;
    axi_write(8'h00, 32'h0000000D, 4'hF, 0, 0, 1, resp);
    chk("ctrl_d_bresp", 32'(resp), 32'd0);
    chk("ctrl_d_init_timing", 32'(init_seen), 32'd1);
    repeat (3) @(negedge clk);
    chk("ctrl_d_init_count", 32'(init_cnt - ic), 32'd1);
    chk("ctrl_d_next_count", 32'(next_cnt - nc), 32'd0);
    chk("ctrl_d_mode", 32'(core_mode), 32'd3);
    axi_read(8'h00, 1, data, resp); chk("ctrl_d_rd", data, 32'h0000000C);

    // INIT and NEXT together: INIT wins, MODE back to 00
    ic = init_cnt; nc = next_cnt;
    axi_write(8'h00, 32'h00000003, 4'hF, 0, 0, 1, resp);
    repeat (3) @(negedge clk);
    chk("ctrl_3_init_count", 32'(init_cnt - ic), 32'd1);
    chk("ctrl_3_next_count", 32'(next_cnt - nc), 32'd0);
    axi_read(8'h00, 1, data, resp); chk("ctrl_3_rd", data, 32'd0);

    // NEXT alone
    ic = init_cnt; nc = next_cnt;
    axi_write(8'h00, 32'h00000002, 4'hF, 0, 0, 1, resp);
    chk("ctrl_2_next_timing", 32'(next_seen), 32'd1);
    repeat (3) @(negedge clk);
    chk("ctrl_2_next_count", 32'(next_cnt - nc), 32'd1);
    chk("ctrl_2_init_count", 32'(init_cnt - ic), 32'd0);

    // Lane 0 disabled: no pulse and MODE unchanged
    ic = init_cnt;
    axi_write(8'h00, 32'h0000000D, 4'b1110, 0, 0, 1, resp);
    repeat (3) @(negedge clk);
    chk("ctrl_nolane0_init", 32'(init_cnt - ic), 32'd0);
    chk("ctrl_nolane0_mode", 32'(core_mode), 32'd0);

    // MODE=01, no pulse
    axi_write(8'h00, 32'h00000004, 4'hF, 0, 0, 1, resp);
    chk("ctrl_4_mode", 32'(core_mode), 32'd1);

    // Core busy
    core_ready = 1'b0;
    nc = next_cnt;
    axi_write(8'h94, 32'h12345678, 4'hF, 0, 0, 1, resp); chk("busy_blk5_bresp", 32'(resp), 32'd2);
    axi_write(8'h00, 32'h00000002, 4'hF, 0, 0, 1, resp); chk("busy_ctrl2_bresp", 32'(resp), 32'd2);
    axi_write(8'h00, 32'h0000000A, 4'hF, 0, 0, 1, resp); chk("busy_ctrla_bresp", 32'(resp), 32'd2);
    repeat (3) @(negedge clk);
    chk("busy_no_next", 32'(next_cnt - nc), 32'd0);
    chk("busy_mode_kept", 32'(core_mode), 32'd1);
    axi_read(8'h94, 1, data, resp); chk("busy_blk5_rd", data, 32'd0);
    axi_read(8'h04, 1, data, resp); chk("busy_status_rd", data, 32'd0);
    axi_write(8'h00, 32'h00000008, 4'hF, 0, 0, 1, resp); chk("busy_ctrl8_bresp", 32'(resp), 32'd0);
    chk("busy_ctrl8_mode", 32'(core_mode), 32'd2);

    // Digest and status
    core_ready = 1'b1;
    core_digest = '0;
    core_digest[511:480] = 32'hDEADBEEF;
    core_digest[31:0] = 32'h0F1E2D3C;
    core_digest_valid = 1'b1;
    axi_read(8'h40, 1, data, resp); chk("digest0_rd", data, 32'hDEADBEEF);
    axi_read(8'h44, 1, data, resp); chk("digest1_rd", data, 32'd0);
    axi_read(8'h7C, 1, data, resp); chk("digest15_rd", data, 32'h0F1E2D3C);
    axi_read(8'h04, 1, data, resp); chk("status_rd", data, 32'h3);
    axi_write(8'h40, 32'h11111111, 4'hF, 0, 0, 1, resp); chk("digest_wr_bresp", 32'(resp), 32'd2);
    axi_write(8'h04, 32'h11111111, 4'hF, 0, 0, 1, resp); chk("status_wr_bresp", 32'(resp), 32'd2);

    // Unmapped addresses
    axi_write(8'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 1, resp); chk("unmapped_bresp", 32'(resp), 32'd0);
    axi_read(8'h0C, 1, data, resp); chk("unmapped_rd", data, 32'd0); chk("unmapped_rresp", 32'(resp), 32'd0);

    // Partial strobe with AW leading W by 3 cycles and BREADY held low 5 cycles
    axi_write(8'h08, 32'h00000000, 4'hF, 0, 0, 1, resp);
    axi_write(8'h08, 32'hFFFFFFFF, 4'b0101, 3, 5, 1, resp); chk("strb_bresp", 32'(resp), 32'd0);
    chk("strb_bvalid_clear", 32'(bvalid), 32'd0);
    axi_read(8'h08, 1, data, resp); chk("strb_rd", data, 32'h00FF00FF);
    axi_read(8'h0B, 1, data, resp); chk("addr_lsb_ignored", data, 32'h00FF00FF);

    // Reset with both responses pending
    axi_write(8'h08, 32'h55AA55AA, 4'hF, 0, 0, 0, resp);
    axi_read(8'h80, 0, data, resp); chk("pending_rd", data, 32'habcd0001);
    chk("pending_bvalid", 32'(bvalid), 32'd1);
    chk("pending_rvalid", 32'(rvalid), 32'd1);
    srst = 1'b1;
    @(negedge clk);
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_mode", 32'(core_mode), 32'd0);
    srst = 1'b0;
    axi_read(8'h08, 1, data, resp); chk("post_rst_scratch", data, 32'd0);
    axi_read(8'h80, 1, data, resp); chk("post_rst_blk0", data, 32'd0);
    chk("post_rst_core_block", 32'(|core_block), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
